mhd_stream_checker: RTL and testbench
=====================================

// Module: mhd_stream_checker
// PURPOSE
//   Streaming Hamming-distance checker for exact/approximate output pairs. Computes popcount(a^b) per accepted pair.
//   Pipelined datapath. Flags each pair with distance > MHD. Accumulates batch statistics.
//   Emits one report per batch over a valid/ready handshake.
//   Sits downstream of the simulation vector source, in place of the combinational distance miter, for sequential error measurement.
// PARAMETERS
//   WIDTH  16  bit width of in_a / in_b
//   MHD    6   max allowed Hamming distance; a sample with hd > MHD is a violation
//   CNT_W  32  width of sample and violation counters
//   HD_W   localparam = $clog2(WIDTH+1), width of a distance value
// PORTS
//   clk             in   1      rising-edge clock
//   rst             in   1      synchronous, active-high reset
//   in_valid        in   1      input pair valid
//   in_ready        out  1      checker accepts pair; transfer = in_valid & in_ready
//   in_a            in   WIDTH  exact output word
//   in_b            in   WIDTH  approximate output word
//   in_last         in   1      marks final pair of the batch
//   rpt_valid       out  1      batch report valid
//   rpt_ready       in   1      report consumed; transfer = rpt_valid & rpt_ready
//   rpt_fail        out  1      at least one violation in the batch
//   rpt_viol_cnt    out  CNT_W  number of pairs with hd > MHD
//   rpt_sample_cnt  out  CNT_W  number of pairs in the batch
//   rpt_max_hd      out  HD_W   largest hd in the batch
//   rpt_first_idx   out  CNT_W  index of the first violating pair (0-based); see CONFIGURATION
//   rpt_first_a     out  WIDTH  in_a of the first violating pair; see CONFIGURATION
//   rpt_first_b     out  WIDTH  in_b of the first violating pair; see CONFIGURATION
// BEHAVIOUR
//   Reset:
//     - state=RUN; all pipeline valids=0; all statistics=0.
//     - rpt_valid=0; all rpt_* outputs=0.
//     - in_ready=1 in the first cycle after reset.
//   Pipeline (one cycle per stage):
//     - S1 registers diff=a^b, valid, last, and the index.
//     - S2 registers hd=popcount(diff), zero-extended to HD_W.
//     - S3 updates statistics: stats updated at edge t+3 for a pair accepted at edge t.
//     - No stalls. Full throughput of 1 pair/clk in RUN.
//   FSM states:
//     - RUN: in_ready=1. Accepting a pair with in_last=1 moves to DRAIN.
//     - DRAIN: in_ready=0. Moves to REPORT once S1 and S2 are both empty and S3 has applied the last pair.
//     - REPORT: rpt_valid=1. rpt_* stays stable until rpt_ready. On handshake: clear all stats and the index, return to RUN.
//     - Timing: in_last accepted at edge t gives rpt_valid=1 from cycle t+3.
//   Stats update per S3 pair:
//     - sample_cnt += 1.
//     - if hd > MHD: viol_cnt += 1, fail = 1.
//     - max_hd = max(max_hd, hd).
//   Arithmetic:
//     - Compare is unsigned and strict: hd == MHD is NOT a violation.
//     - Both counters saturate at 2^CNT_W-1 and never wrap.
//     - The index counter also saturates.
//   Boundaries:
//     - A single-pair batch (in_last on the first pair) is legal.
//     - Empty batches cannot occur.
//     - rpt_ready held high gives back-to-back batches with RUN re-entered the cycle after the handshake.
//     - rst mid-batch or mid-report aborts the batch: no report is emitted, and outputs return to reset values.
//     - in_a / in_b / in_last are ignored when in_valid=0 or in_ready=0.
// CONFIGURATION
//   MHD_FIRST_CAPTURE_EN
//     - Defined: S3 captures idx/a/b of the first pair with hd > MHD into rpt_first_*. The a/b values are carried down the pipeline.
//     - Defined: later violations do not overwrite the capture. Capture is cleared on report handshake.
//     - Defined: rpt_first_* = 0 when rpt_fail=0.
//     - Undefined: rpt_first_* are tied to 0 and no capture registers exist. Ports are present in both builds.
// TESTING
//   - Default params; 4 pairs a=b=16'h1234, last on the 4th -> rpt_valid at t+3; fail=0, viol=0, samples=4, max_hd=0.
//   - Pairs hd=6 (a=16'h003F,b=0), hd=7 (16'h007F,0), hd=16 (16'hFFFF,0), last on the 3rd -> viol=2, fail=1, max_hd=16.
//     With the macro: first_idx=1, first_a=16'h007F, first_b=0.
//   - rpt_ready held low 5 cycles -> rpt_* stable and in_ready=0 throughout.
//     On handshake: next batch of 1 pair hd=0 reports samples=1, fail=0.
//   - Single-pair batch hd=7 with in_valid toggling every cycle -> exactly one report: samples=1, viol=1.
//   - CNT_W=4; 20 pairs all hd=8 -> viol_cnt=15 and sample_cnt=15, both saturated.
//   - rst asserted 2 cycles after in_last -> rpt_valid never rises; outputs 0.
//     The next batch's counts exclude the aborted pairs.

Source files
------------

// File: rtl/mhd_stream_checker_if.sv
// Handshake bundle for mhd_stream_checker: pair input stream plus batch report stream.
// master = pair source / report sink, slave = checker.
interface mhd_stream_checker_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = 32,
  parameter int unsigned HD_W  = $clog2(WIDTH + 1)
);

  // Pair input stream
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_last;

  // Batch report stream
  logic             rpt_valid;
  logic             rpt_ready;
  logic             rpt_fail;
  logic [CNT_W-1:0] rpt_viol_cnt;
  logic [CNT_W-1:0] rpt_sample_cnt;
  logic [HD_W-1:0]  rpt_max_hd;
  logic [CNT_W-1:0] rpt_first_idx;
  logic [WIDTH-1:0] rpt_first_a;
  logic [WIDTH-1:0] rpt_first_b;

  modport master (
    output in_valid, in_a, in_b, in_last, rpt_ready,
    input  in_ready, rpt_valid, rpt_fail, rpt_viol_cnt, rpt_sample_cnt, rpt_max_hd,
    input  rpt_first_idx, rpt_first_a, rpt_first_b
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, rpt_ready,
    output in_ready, rpt_valid, rpt_fail, rpt_viol_cnt, rpt_sample_cnt, rpt_max_hd,
    output rpt_first_idx, rpt_first_a, rpt_first_b
  );

endinterface

// File: rtl/mhd_stream_checker.sv
// Streaming Hamming-distance checker.
// Each accepted (a, b) pair flows through a three-stage pipeline (xor, popcount, compare) and
// is folded into batch statistics; a batch ends with in_last and is reported once over a
// valid/ready handshake.
// Optional build macro MHD_FIRST_CAPTURE_EN: record index and operands of the first violating
// pair of each batch. Without it the rpt_first_* outputs read 0 and no capture logic exists.
module mhd_stream_checker #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned MHD   = 6,
  parameter int unsigned CNT_W = 32
) (
  input logic                 clk,
  input logic                 rst,
  mhd_stream_checker_if.slave bus
);

  localparam int unsigned HD_W = $clog2(WIDTH + 1);
  localparam logic [HD_W-1:0] MhdLim = HD_W'(MHD);

  typedef enum logic [1:0] {
    StRun,
    StDrain,
    StReport
  } state_e;

  function automatic logic [HD_W-1:0] popcount(input logic [WIDTH-1:0] d);
    logic [HD_W-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      c = c + HD_W'(d[i]);
    end
    return c;
  endfunction

  state_e state_q;
  logic   in_ready_q;
  logic   rpt_valid_q;

  logic accept;
  logic rpt_hs;

  // Pipeline stage registers
  logic             s1_valid, s1_last;
  logic [WIDTH-1:0] s1_diff;
  logic             s2_valid, s2_last;
  logic [HD_W-1:0]  s2_hd;
  logic             s3_valid, s3_last, s3_viol;
  logic [HD_W-1:0]  s3_hd;

  // Batch statistics
  logic             fail_q;
  logic [CNT_W-1:0] viol_cnt_q;
  logic [CNT_W-1:0] sample_cnt_q;
  logic [HD_W-1:0]  max_hd_q;

`ifdef MHD_FIRST_CAPTURE_EN
  logic [CNT_W-1:0] idx_q;
  logic [CNT_W-1:0] s1_idx, s2_idx, s3_idx;
  logic [WIDTH-1:0] s1_a, s1_b, s2_a, s2_b, s3_a, s3_b;
  logic [CNT_W-1:0] first_idx_q;
  logic [WIDTH-1:0] first_a_q, first_b_q;
`endif

  assign accept = bus.in_valid & in_ready_q;
  assign rpt_hs = rpt_valid_q & bus.rpt_ready;

  // Batch control: accept until in_last, drain the pipeline, hold the report until taken
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      in_ready_q  <= 1'b1;
      rpt_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (accept && bus.in_last) begin
            state_q    <= StDrain;
            in_ready_q <= 1'b0;
          end
        end
        StDrain: begin
          // The last pair is in S3 and is folded into the stats on this same edge.
          if (!s1_valid && !s2_valid && s3_valid && s3_last) begin
            state_q     <= StReport;
            rpt_valid_q <= 1'b1;
          end
        end
        StReport: begin
          if (bus.rpt_ready) begin
            state_q     <= StRun;
            rpt_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= StRun;
          in_ready_q  <= 1'b1;
          rpt_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Pipeline valid/last flags; only these need a reset
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s3_valid <= 1'b0;
      s3_last  <= 1'b0;
    end else begin
      s1_valid <= accept;
      s1_last  <= accept & bus.in_last;
      s2_valid <= s1_valid;
      s2_last  <= s1_last;
      s3_valid <= s2_valid;
      s3_last  <= s2_last;
    end
  end

  // Pipeline datapath: S1 xor, S2 popcount, S3 strict compare against MHD
  always_ff @(posedge clk) begin
    s1_diff <= bus.in_a ^ bus.in_b;
    s2_hd   <= popcount(s1_diff);
    s3_hd   <= s2_hd;
    s3_viol <= (s2_hd > MhdLim);
  end

`ifdef MHD_FIRST_CAPTURE_EN
  // Carry index and operands alongside the distance for first-violation capture
  always_ff @(posedge clk) begin
    s1_idx <= idx_q;
    s1_a   <= bus.in_a;
    s1_b   <= bus.in_b;
    s2_idx <= s1_idx;
    s2_a   <= s1_a;
    s2_b   <= s1_b;
    s3_idx <= s2_idx;
    s3_a   <= s2_a;
    s3_b   <= s2_b;
  end

  // Per-batch pair index, saturating, cleared when the report is taken
  always_ff @(posedge clk) begin
    if (rst || rpt_hs) begin
      idx_q <= '0;
    end else if (accept && (idx_q != '1)) begin
      idx_q <= idx_q + CNT_W'(1);
    end
  end
`endif

  // Fold each S3 result into the batch statistics; counters saturate rather than wrap
  always_ff @(posedge clk) begin
    if (rst || rpt_hs) begin
      fail_q       <= 1'b0;
      viol_cnt_q   <= '0;
      sample_cnt_q <= '0;
      max_hd_q     <= '0;
`ifdef MHD_FIRST_CAPTURE_EN
      first_idx_q  <= '0;
      first_a_q    <= '0;
      first_b_q    <= '0;
`endif
    end else if (s3_valid) begin
      if (sample_cnt_q != '1) begin
        sample_cnt_q <= sample_cnt_q + CNT_W'(1);
      end
      if (s3_hd > max_hd_q) begin
        max_hd_q <= s3_hd;
      end
      if (s3_viol) begin
        fail_q <= 1'b1;
        if (viol_cnt_q != '1) begin
          viol_cnt_q <= viol_cnt_q + CNT_W'(1);
        end
`ifdef MHD_FIRST_CAPTURE_EN
        // fail_q still low means this is the first violation of the batch
        if (!fail_q) begin
          first_idx_q <= s3_idx;
          first_a_q   <= s3_a;
          first_b_q   <= s3_b;
        end
`endif
      end
    end
  end

  assign bus.in_ready       = in_ready_q;
  assign bus.rpt_valid      = rpt_valid_q;
  assign bus.rpt_fail       = fail_q;
  assign bus.rpt_viol_cnt   = viol_cnt_q;
  assign bus.rpt_sample_cnt = sample_cnt_q;
  assign bus.rpt_max_hd     = max_hd_q;

`ifdef MHD_FIRST_CAPTURE_EN
  assign bus.rpt_first_idx = first_idx_q;
  assign bus.rpt_first_a   = first_a_q;
  assign bus.rpt_first_b   = first_b_q;
`else
  assign bus.rpt_first_idx = '0;
  assign bus.rpt_first_a   = '0;
  assign bus.rpt_first_b   = '0;
`endif

endmodule

// File: tb/tb_mhd_stream_checker.sv
// Bench for mhd_stream_checker: table of pairs with hand-computed distances, a reference model
// that turns each finished batch into an expected report on a queue, a monitor that pops and
// compares on every report handshake, and hand-written sequences for latency, stall,
// abort-by-reset and counter saturation (second instance with CNT_W=4).
module tb_mhd_stream_checker;

  localparam int unsigned Mhd = 6;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mhd_stream_checker_if #(.WIDTH(16), .CNT_W(32)) bus ();
  mhd_stream_checker_if #(.WIDTH(16), .CNT_W(4))  sbus ();

  mhd_stream_checker #(.WIDTH(16), .MHD(Mhd), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  mhd_stream_checker #(.WIDTH(16), .MHD(Mhd), .CNT_W(4)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (sbus)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        last;
    int unsigned hd;
  } vec_t;

  typedef struct {
    logic        fail;
    logic [31:0] viol;
    logic [31:0] samples;
    logic [4:0]  max_hd;
    logic [31:0] first_idx;
    logic [15:0] first_a;
    logic [15:0] first_b;
  } rpt_t;

  int n_chk  = 0;
  int n_fail = 0;
  int n_rpt  = 0;

  rpt_t exp_q[$];

  // Reference model accumulator for the batch in flight
  int unsigned m_samples = 0, m_viol = 0, m_max = 0, m_idx = 0;
  logic        m_fail = 1'b0;
  logic [31:0] m_first_idx = '0;
  logic [15:0] m_first_a = '0, m_first_b = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_pair(input vec_t v);
    rpt_t r;
    m_samples++;
    if (v.hd > m_max) m_max = v.hd;
    if (v.hd > Mhd) begin
      m_viol++;
      if (!m_fail) begin
        m_first_idx = m_idx;
        m_first_a   = v.a;
        m_first_b   = v.b;
      end
      m_fail = 1'b1;
    end
    m_idx++;
    if (v.last) begin
      r.fail    = m_fail;
      r.viol    = m_viol;
      r.samples = m_samples;
      r.max_hd  = 5'(m_max);
`ifdef MHD_FIRST_CAPTURE_EN
      r.first_idx = m_first_idx;
      r.first_a   = m_first_a;
      r.first_b   = m_first_b;
`else
      r.first_idx = '0;
      r.first_a   = '0;
      r.first_b   = '0;
`endif
      exp_q.push_back(r);
      m_samples = 0;
      m_viol    = 0;
      m_max     = 0;
      m_idx     = 0;
      m_fail    = 1'b0;
    end
  endtask

  // Present one pair, wait (bounded) for in_ready, return #1 after the accepting edge
  task automatic send(input vec_t v);
    int waited;
    bus.in_valid = 1'b1;
    bus.in_a     = v.a;
    bus.in_b     = v.b;
    bus.in_last  = v.last;
    waited = 0;
    while (!bus.in_ready && waited < 100) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (!bus.in_ready) begin
      chk("send_in_ready_timeout", 64'(bus.in_ready), 64'(1));
    end else begin
      @(posedge clk);
      model_pair(v);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("reports_drained", 64'(exp_q.size()), 64'(0));
  endtask

  // Scoreboard: compare every report at the handshake, sampled on the falling edge
  always @(negedge clk) begin
    rpt_t e;
    if (!rst && bus.rpt_valid && bus.rpt_ready) begin
      n_rpt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_report", 64'(1), 64'(0));
      end else begin
        e = exp_q.pop_front();
        chk("rpt_fail",       64'(bus.rpt_fail),       64'(e.fail));
        chk("rpt_viol_cnt",   64'(bus.rpt_viol_cnt),   64'(e.viol));
        chk("rpt_sample_cnt", 64'(bus.rpt_sample_cnt), 64'(e.samples));
        chk("rpt_max_hd",     64'(bus.rpt_max_hd),     64'(e.max_hd));
        chk("rpt_first_idx",  64'(bus.rpt_first_idx),  64'(e.first_idx));
        chk("rpt_first_a",    64'(bus.rpt_first_a),    64'(e.first_a));
        chk("rpt_first_b",    64'(bus.rpt_first_b),    64'(e.first_b));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    int   base_rpt;
    int   k;

    vecs[0] = '{a: 16'h1234, b: 16'h1234, last: 1'b0, hd: 0};
    vecs[1] = '{a: 16'h1234, b: 16'h1234, last: 1'b0, hd: 0};
    vecs[2] = '{a: 16'h1234, b: 16'h1234, last: 1'b0, hd: 0};
    vecs[3] = '{a: 16'h1234, b: 16'h1234, last: 1'b1, hd: 0};
    vecs[4] = '{a: 16'h003F, b: 16'h0000, last: 1'b0, hd: 6};
    vecs[5] = '{a: 16'h007F, b: 16'h0000, last: 1'b0, hd: 7};
    vecs[6] = '{a: 16'hFFFF, b: 16'h0000, last: 1'b1, hd: 16};
    vecs[7] = '{a: 16'h5A5A, b: 16'h5A5A, last: 1'b1, hd: 0};

    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_a       = '0;
    bus.in_b       = '0;
    bus.in_last    = 1'b0;
    bus.rpt_ready  = 1'b0;
    sbus.in_valid  = 1'b0;
    sbus.in_a      = '0;
    sbus.in_b      = '0;
    sbus.in_last   = 1'b0;
    sbus.rpt_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("reset_in_ready",   64'(bus.in_ready),       64'(1));
    chk("reset_rpt_valid",  64'(bus.rpt_valid),      64'(0));
    chk("reset_fail",       64'(bus.rpt_fail),       64'(0));
    chk("reset_viol",       64'(bus.rpt_viol_cnt),   64'(0));
    chk("reset_samples",    64'(bus.rpt_sample_cnt), 64'(0));
    chk("reset_max_hd",     64'(bus.rpt_max_hd),     64'(0));
    chk("reset_first_idx",  64'(bus.rpt_first_idx),  64'(0));
    chk("reset_first_a",    64'(bus.rpt_first_a),    64'(0));

    // Batch A: four equal pairs, latency from in_last to rpt_valid is three edges
    for (int i = 0; i < 4; i++) begin
      send(vecs[i]);
    end
    chk("lat_edge_t_rpt_valid", 64'(bus.rpt_valid), 64'(0));
    chk("lat_edge_t_in_ready",  64'(bus.in_ready),  64'(0));
    for (int j = 1; j <= 3; j++) begin
      @(posedge clk);
      #1;
      chk($sformatf("lat_edge_t+%0d_rpt_valid", j), 64'(bus.rpt_valid), 64'(j == 3));
    end

    // Report held while rpt_ready is low
    for (int j = 0; j < 5; j++) begin
      chk("stall_rpt_valid",  64'(bus.rpt_valid),      64'(1));
      chk("stall_in_ready",   64'(bus.in_ready),       64'(0));
      chk("stall_samples",    64'(bus.rpt_sample_cnt), 64'(4));
      chk("stall_max_hd",     64'(bus.rpt_max_hd),     64'(0));
      @(posedge clk);
      #1;
    end
    bus.rpt_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("after_hs_in_ready",  64'(bus.in_ready),       64'(1));
    chk("after_hs_rpt_valid", 64'(bus.rpt_valid),      64'(0));
    chk("after_hs_samples",   64'(bus.rpt_sample_cnt), 64'(0));

    // Batches B and C back-to-back with rpt_ready held high
    for (int i = 4; i < 8; i++) begin
      send(vecs[i]);
    end
    wait_drain();
    chk("report_count_abc", 64'(n_rpt), 64'(3));

    // Single-pair batch with in_valid toggling around it; junk must be ignored
    bus.rpt_ready = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = 16'hFFFF;
    bus.in_b      = 16'h0000;
    bus.in_last   = 1'b1;
    @(posedge clk);
    #1;
    send('{a: 16'h007F, b: 16'h0000, last: 1'b1, hd: 7});
    for (int j = 0; j < 6; j++) begin
      bus.in_valid = (j % 2 == 0);
      bus.in_a     = 16'hFFFF;
      bus.in_b     = 16'h0000;
      bus.in_last  = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    base_rpt      = n_rpt;
    bus.rpt_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rpt_ready = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("toggle_one_report",     64'(n_rpt - base_rpt), 64'(1));
    chk("toggle_rpt_valid_low",  64'(bus.rpt_valid),    64'(0));
    chk("toggle_queue_empty",    64'(exp_q.size()),     64'(0));

    // Reset two edges after in_last aborts the batch
    send('{a: 16'h0101, b: 16'h0000, last: 1'b0, hd: 2});
    send('{a: 16'h7F00, b: 16'h0000, last: 1'b1, hd: 7});
    void'(exp_q.pop_back());
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    base_rpt = n_rpt;
    for (int j = 0; j < 6; j++) begin
      chk("abort_rpt_valid", 64'(bus.rpt_valid), 64'(0));
      @(posedge clk);
      #1;
    end
    chk("abort_in_ready", 64'(bus.in_ready),       64'(1));
    chk("abort_samples",  64'(bus.rpt_sample_cnt), 64'(0));
    chk("abort_viol",     64'(bus.rpt_viol_cnt),   64'(0));
    chk("abort_fail",     64'(bus.rpt_fail),       64'(0));
    chk("abort_max_hd",   64'(bus.rpt_max_hd),     64'(0));
    bus.rpt_ready = 1'b1;
    send('{a: 16'h00FE, b: 16'h0000, last: 1'b1, hd: 7});
    wait_drain();
    chk("abort_then_one_report", 64'(n_rpt - base_rpt), 64'(1));

    // Saturation: CNT_W=4, twenty pairs of hd=8
    chk("sat_in_ready", 64'(sbus.in_ready), 64'(1));
    for (int i = 0; i < 20; i++) begin
      sbus.in_valid = 1'b1;
      sbus.in_a     = 16'h00FF;
      sbus.in_b     = 16'h0000;
      sbus.in_last  = (i == 19);
      @(posedge clk);
      #1;
    end
    sbus.in_valid = 1'b0;
    sbus.in_last  = 1'b0;
    k = 0;
    while (!sbus.rpt_valid && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("sat_rpt_valid", 64'(sbus.rpt_valid),      64'(1));
    chk("sat_viol",      64'(sbus.rpt_viol_cnt),   64'(15));
    chk("sat_samples",   64'(sbus.rpt_sample_cnt), 64'(15));
    chk("sat_max_hd",    64'(sbus.rpt_max_hd),     64'(8));
    chk("sat_fail",      64'(sbus.rpt_fail),       64'(1));
`ifdef MHD_FIRST_CAPTURE_EN
    chk("sat_first_idx", 64'(sbus.rpt_first_idx),  64'(0));
    chk("sat_first_a",   64'(sbus.rpt_first_a),    64'(16'h00FF));
`else
    chk("sat_first_idx", 64'(sbus.rpt_first_idx),  64'(0));
    chk("sat_first_a",   64'(sbus.rpt_first_a),    64'(0));
`endif
    sbus.rpt_ready = 1'b1;
    @(posedge clk);
    #1;
    sbus.rpt_ready = 1'b0;
    chk("sat_rpt_taken",   64'(sbus.rpt_valid),      64'(0));
    chk("sat_cleared",     64'(sbus.rpt_sample_cnt), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
